// File: rtl/cpu_mem_pkg.sv
// Shared memory-command encodings and MEM-stage FSM states,
// used by both the control unit and the memory access unit.
package cpu_mem_pkg;

  // Load type codes carried on Load[2:0]; unlisted codes behave as lw
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;

  // Store type codes carried on Store[1:0]; 2'b11 behaves as sw
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } acc_size_t;

  function automatic acc_size_t load_size(input logic [2:0] ld);
    case (ld)
      LD_LB, LD_LBU: load_size = SIZE_B;
      LD_LH, LD_LHU: load_size = SIZE_H;
      default:       load_size = SIZE_W;
    endcase
  endfunction

  function automatic acc_size_t store_size(input logic [1:0] st);
    case (st)
      ST_SB:   store_size = SIZE_B;
      ST_SH:   store_size = SIZE_H;
      default: store_size = SIZE_W;
    endcase
  endfunction

  // Natural alignment: bytes anywhere, halves on even, words on multiples of 4
  function automatic logic is_aligned(input acc_size_t sz, input logic [1:0] off);
    case (sz)
      SIZE_B:  is_aligned = 1'b1;
      SIZE_H:  is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, 32-bit words, per-byte write enables,
// registered read port. Contents are not reset.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane write and read-before-write word read on every enabled edge
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: executes one memory command at a time
// against the data RAM, inserts WAIT_CYCLES wait states, stalls the
// pipeline until the access retires and returns extended load data.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRd,
  input  logic        memWt,
  input  logic [2:0]  Load,
  input  logic [1:0]  Store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  mem_state_t          state;
  logic [3:0]          cnt;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          load_q;
  logic [1:0]          store_q;
  logic                is_store_q;

  logic                req;
  logic                req_aligned;
  logic                req_ok;
  logic                last_access;
  logic                ram_en;
  logic [3:0]          ram_be;
  logic [31:0]         ram_wdata;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_q;

  // Upper address bits alias onto the RAM and are deliberately dropped
  logic                unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Sign/zero extension of the addressed lane(s) of a RAM word
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  ld,
                                              input logic [1:0]  off);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (ld)
      LD_LB:   load_extend = 32'(b);
      LD_LBU:  load_extend = {24'd0, b};
      LD_LH:   load_extend = 32'(h);
      LD_LHU:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Byte-enable pattern for a store of the given type at lane offset off
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
    case (st)
      ST_SB:   store_be = 4'b0001 << off;
      ST_SH:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the low byte/half across the word so any lane can pick it up
  function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] d);
    case (st)
      ST_SB:   store_data = {4{d[7:0]}};
      ST_SH:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // A simultaneous read+write is a store, so alignment follows the store type
  assign req         = memRd | memWt;
  assign req_aligned = memWt ? is_aligned(store_size(Store), addr[1:0])
                             : is_aligned(load_size(Load), addr[1:0]);
  assign req_ok      = (state == IDLE) & req & req_aligned;

  assign misalign = (state == IDLE) & req & ~req_aligned;
  assign stall    = (state == ACCESS) | req_ok;

  assign last_access = (state == ACCESS) && (cnt == 4'd0);

  // Live address on the launching edge, latched address while accessing
  assign ram_addr  = (state == IDLE) ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
  assign ram_en    = req_ok | (state == ACCESS);
  assign ram_be    = (last_access && is_store_q && !rst) ? store_be(store_q, addr_q[1:0]) : 4'b0000;
  assign ram_wdata = store_data(store_q, wdata_q);

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Latch the command when it is accepted; held stable for the whole access
  always_ff @(posedge clk) begin
    if (req_ok) begin
      addr_q     <= addr[ADDR_W+1:0];
      wdata_q    <= wdata;
      load_q     <= Load;
      store_q    <= Store;
      is_store_q <= memWt;
    end
  end

  // Access FSM: accept in IDLE, count wait states in ACCESS, retire in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            state <= ACCESS;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            if (!is_store_q) rdata <= load_extend(ram_q, load_q, addr_q[1:0]);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (default size with one wait state,
// and a 16-word RAM with three wait states), a constant vector table, hand
// sequences for wrap-around and reset-during-access, and a randomized phase
// checked against an array-based reference model.
module tb_mem_access_unit;

  localparam int W0 = 1;
  localparam int A0 = 10;
  localparam int W1 = 3;
  localparam int A1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rd0, wt0, stall0, mis0;
  logic [2:0]  ld0;
  logic [1:0]  st0;
  logic [31:0] a0, d0, q0;
  logic        rst1, rd1, wt1, stall1, mis1;
  logic [2:0]  ld1;
  logic [1:0]  st1;
  logic [31:0] a1, d1, q1;

  mem_access_unit #(.ADDR_W(A0), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .rst(rst0), .memRd(rd0), .memWt(wt0), .Load(ld0), .Store(st0),
    .addr(a0), .wdata(d0), .rdata(q0), .stall(stall0), .misalign(mis0));

  mem_access_unit #(.ADDR_W(A1), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst(rst1), .memRd(rd1), .memWt(wt1), .Load(ld1), .Store(st1),
    .addr(a1), .wdata(d1), .rdata(q1), .stall(stall1), .misalign(mis1));

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mdl0 [1024];
  logic [31:0] mdl1 [16];
  logic [31:0] mq0, mq1;

  typedef struct {
    logic        rd;
    logic        wt;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic        mis;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic rd, input logic wt, input logic [2:0] ld,
                       input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    if (which == 0) begin
      rd0 = rd; wt0 = wt; ld0 = ld; st0 = st; a0 = a; d0 = d;
    end else begin
      rd1 = rd; wt1 = wt; ld1 = ld; st1 = st; a1 = a; d1 = d;
    end
  endtask

  task automatic sample(input int which, output logic s, output logic m, output logic [31:0] q);
    if (which == 0) begin
      s = stall0; m = mis0; q = q0;
    end else begin
      s = stall1; m = mis1; q = q1;
    end
  endtask

  // Hold a command until the unit stops stalling; report stall length,
  // first-cycle misalign and rdata seen in the first non-stalled cycle.
  task automatic run_op(input int which, input logic rd, input logic wt, input logic [2:0] ld,
                        input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int scnt, output logic m_first,
                        output logic done);
    logic s, m;
    logic [31:0] qq;
    drive(which, rd, wt, ld, st, a, d);
    scnt = 0; done = 1'b0; q = 32'hx; m_first = 1'bx;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      sample(which, s, m, qq);
      if (i == 0) m_first = m;
      if (s) scnt++;
      else begin
        done = 1'b1;
        q = qq;
        break;
      end
    end
    @(posedge clk); #1;
    drive(which, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic expect_op(input string nm, input int which, input logic rd, input logic wt,
                           input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_q, input logic exp_mis);
    logic [31:0] q;
    int scnt, exp_s;
    logic mf, done;
    run_op(which, rd, wt, ld, st, a, d, q, scnt, mf, done);
    exp_s = (exp_mis || !(rd || wt)) ? 0 : ((which == 0) ? W0 : W1) + 2;
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " stall_cycles"}, 32'(scnt), 32'(exp_s));
    chk({nm, " misalign"}, 32'(mf), 32'(exp_mis));
    chk({nm, " rdata"}, q, exp_q);
  endtask

  // Reference behaviour from the access rules, using plain arithmetic
  task automatic model_op(input int which, input logic rd, input logic wt, input logic [2:0] ld,
                          input logic [1:0] st, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] exp_q, output logic exp_mis);
    int off, idx;
    logic [31:0] w, m, v;
    bit al;
    off = int'(a % 4);
    idx = (which == 0) ? int'((a / 4) % 1024) : int'((a / 4) % 16);
    w = (which == 0) ? mdl0[idx] : mdl1[idx];
    if (wt) al = (st == 2'd0) || ((st == 2'd1) ? (off % 2 == 0) : (off == 0));
    else    al = (ld <= 3'd1) || ((ld == 3'd2 || ld == 3'd3) ? (off % 2 == 0) : (off == 0));
    exp_mis = (rd || wt) && !al;
    exp_q = (which == 0) ? mq0 : mq1;
    if ((rd || wt) && al) begin
      if (wt) begin
        if (st == 2'd0) begin
          m = 32'hFF << (8 * off);
          w = (w & ~m) | ((d & 32'hFF) << (8 * off));
        end else if (st == 2'd1) begin
          m = 32'hFFFF << (8 * off);
          w = (w & ~m) | ((d & 32'hFFFF) << (8 * off));
        end else begin
          w = d;
        end
        if (which == 0) mdl0[idx] = w; else mdl1[idx] = w;
      end else begin
        v = w >> (8 * off);
        case (ld)
          3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
          3'd1: v = v & 32'hFF;
          3'd2: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
          3'd3: v = v & 32'hFFFF;
          default: v = w;
        endcase
        exp_q = v;
        if (which == 0) mq0 = v; else mq1 = v;
      end
    end
  endtask

  task automatic rand_phase(input int which, input int nops);
    logic [31:0] a, d, eq;
    logic em, rd, wt;
    logic [2:0] ld;
    logic [1:0] st;
    int nwords, r;
    nwords = (which == 0) ? 8 : 16;
    for (int i = 0; i < nwords; i++) begin
      a = (which == 0) ? (($urandom & 32'hFFFFF000) | 32'h200 | 32'(i * 4))
                       : (($urandom & 32'hFFFFFFC0) | 32'(i * 4));
      d = $urandom;
      model_op(which, 1'b0, 1'b1, 3'd4, 2'd2, a, d, eq, em);
      expect_op("rand_prewrite", which, 1'b0, 1'b1, 3'd4, 2'd2, a, d, eq, em);
    end
    for (int i = 0; i < nops; i++) begin
      r = $urandom_range(0, 9);
      rd = (r == 1) || (r >= 2 && r <= 5);
      wt = (r == 1) || (r >= 6);
      ld = 3'($urandom_range(0, 7));
      st = 2'($urandom_range(0, 3));
      a = (which == 0) ? (($urandom & 32'hFFFFF000) | 32'h200 | 32'($urandom_range(0, 31)))
                       : (($urandom & 32'hFFFFFFC0) | 32'($urandom_range(0, 63)));
      d = $urandom;
      model_op(which, rd, wt, ld, st, a, d, eq, em);
      expect_op("rand_op", which, rd, wt, ld, st, a, d, eq, em);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // sw/lw/lb/lbu/lh/lhu plus lane stores, misalignment, rd+wt and code aliases
    tbl[0]  = '{1'b0, 1'b1, 3'd4, 2'd2, 32'h10, 32'h8040C0FF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h10, 32'h0,        32'h8040C0FF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h0,        32'hFFFFFFFF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'd1, 2'd0, 32'h10, 32'h0,        32'h000000FF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'd2, 2'd0, 32'h12, 32'h0,        32'hFFFF8040, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'd3, 2'd0, 32'h12, 32'h0,        32'h00008040, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3'd4, 2'd2, 32'h10, 32'h0,        32'h00008040, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'd4, 2'd0, 32'h11, 32'h12345678, 32'h00008040, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h10, 32'h0,        32'h00007800, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'd4, 2'd1, 32'h12, 32'h0000ABCD, 32'h00007800, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h10, 32'h0,        32'hABCD7800, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 3'd4, 2'd2, 32'h20, 32'h0,        32'hABCD7800, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h13, 32'h0,        32'hABCD7800, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 3'd4, 2'd1, 32'h21, 32'hFFFF1111, 32'hABCD7800, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 3'd2, 2'd0, 32'h11, 32'h0,        32'hABCD7800, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h20, 32'h0,        32'h00000000, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h10, 32'h0,        32'hABCD7800, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 3'd4, 2'd2, 32'h10, 32'h11223344, 32'hABCD7800, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 3'd7, 2'd0, 32'h10, 32'h0,        32'h11223344, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h13, 32'h0,        32'h00000011, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 3'd3, 2'd0, 32'h12, 32'h0,        32'h00001122, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 3'd4, 2'd3, 32'h14, 32'h55667788, 32'h00001122, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h14, 32'h0,        32'h55667788, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 3'd4, 2'd0, 32'h17, 32'h000000AA, 32'h55667788, 1'b0};
    tbl[24] = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h17, 32'h0,        32'hFFFFFFAA, 1'b0};
    tbl[25] = '{1'b0, 1'b1, 3'd4, 2'd2, 32'h16, 32'h99999999, 32'hFFFFFFAA, 1'b1};
    tbl[26] = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h14, 32'h0,        32'hAA667788, 1'b0};

    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset u0 stall", 32'(stall0), 32'd0);
    chk("reset u0 rdata", q0, 32'd0);
    chk("reset u0 misalign", 32'(mis0), 32'd0);
    chk("reset u1 stall", 32'(stall1), 32'd0);
    chk("reset u1 rdata", q1, 32'd0);
    chk("reset u1 misalign", 32'(mis1), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      expect_op($sformatf("vec%0d", i), 0, tbl[i].rd, tbl[i].wt, tbl[i].ld, tbl[i].st,
                tbl[i].a, tbl[i].d, tbl[i].q, tbl[i].mis);
    end

    // 16-word RAM: aliasing and simultaneous read+write
    expect_op("wrap_sw",   1, 1'b0, 1'b1, 3'd4, 2'd2, 32'h40, 32'hDEADBEEF, 32'h00000000, 1'b0);
    expect_op("wrap_lw",   1, 1'b1, 1'b0, 3'd4, 2'd0, 32'h00, 32'h0,        32'hDEADBEEF, 1'b0);
    expect_op("rdwt_sw",   1, 1'b1, 1'b1, 3'd4, 2'd2, 32'h04, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0);
    expect_op("rdwt_lw",   1, 1'b1, 1'b0, 3'd4, 2'd0, 32'h44, 32'h0,        32'hCAFEF00D, 1'b0);
    expect_op("pre_rst_sw", 1, 1'b0, 1'b1, 3'd4, 2'd2, 32'h08, 32'h0BADF00D, 32'hCAFEF00D, 1'b0);

    // Reset during the second ACCESS cycle of a store with three wait states
    drive(1, 1'b0, 1'b1, 3'd4, 2'd2, 32'h08, 32'h13579BDF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(negedge clk);
    chk("rst_access stall_before", 32'(stall1), 32'd1);
    @(posedge clk); #1;
    rst1 = 1'b0;
    drive(1, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rst_access stall_after", 32'(stall1), 32'd0);
    chk("rst_access rdata_after", q1, 32'd0);
    @(posedge clk); #1;
    expect_op("rst_access word_kept", 1, 1'b1, 1'b0, 3'd4, 2'd0, 32'h08, 32'h0, 32'h0BADF00D, 1'b0);

    // Randomized phase against the reference model
    mq0 = 32'hAA667788;
    mq1 = 32'h0BADF00D;
    rand_phase(0, 60);
    rand_phase(1, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
